lc3b_write_buffer: RTL and testbench

Parametrised write-back buffer between the L1 data cache and physical memory (or the L2/arbiter port). It absorbs dirty-line evictions so the cache can refill without waiting for the write-back. It coalesces repeat evictions of the same line and forwards buffered lines on cache-miss lookups. It drains in FIFO order whenever the downstream port is not held for a read.

---
 rtl/lc3b_write_buffer_pkg.sv | 23 ++
 rtl/lc3b_write_buffer_if.sv | 35 +++
 rtl/lc3b_write_buffer_match.sv | 43 ++++
 rtl/lc3b_write_buffer.sv | 157 +++++++++++++++
 tb/tb_lc3b_write_buffer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_write_buffer_pkg.sv
// Shared types for the LC-3b L1 write-back buffer.
// Holds the line/address typedefs, the buffer entry payload and the drain FSM encoding.
package lc3b_write_buffer_pkg;

  localparam int unsigned LC3B_LINE_W = 128;
  localparam int unsigned LC3B_ADDR_W = 12;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_line_addr;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  // One buffered eviction
  typedef struct packed {
    logic          valid;
    lc3b_line_addr addr;
    lc3b_line      data;
  } lc3b_wb_entry;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_DRAIN = 1'b1
  } lc3b_wb_state;

endpackage

// File: rtl/lc3b_write_buffer_if.sv
// Bus bundle between the L1 cache, the miss path, the arbiter and the write buffer.
// slave  : the write buffer (consumes pushes/lookups, drives pmem_* requests)
// master : the surrounding system (cache, miss path, arbiter, memory port)
interface lc3b_write_buffer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LINE_W = 128
) ();

  logic              in_write;
  logic [ADDR_W-1:0] in_addr;
  logic [LINE_W-1:0] in_data;
  logic              in_resp;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_hit;
  logic [LINE_W-1:0] lk_data;
  logic              hold;
  logic              flush;
  logic              empty;
  logic              full;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;

  modport slave (
    input  in_write, in_addr, in_data, lk_addr, hold, flush, pmem_resp,
    output in_resp, lk_hit, lk_data, empty, full, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output in_write, in_addr, in_data, lk_addr, hold, flush, pmem_resp,
    input  in_resp, lk_hit, lk_data, empty, full, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/lc3b_write_buffer_match.sv
// Address comparator over the buffer entries with newest-first priority.
// Ports:
//   valid_i     entry valid bits
//   addr_i      entry line addresses
//   head_i      index of the oldest entry
//   tail_i      index of the next free slot (newest entry is tail_i-1)
//   query_i     line address to search for
//   excl_head_i ignore the head entry (it is being written downstream)
//   hit_o       some eligible entry matches
//   idx_o       index of the newest matching entry
module lc3b_wb_match #(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned ADDR_W = 12,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [PTR_W-1:0]  head_i,
  input  logic [PTR_W-1:0]  tail_i,
  input  logic [ADDR_W-1:0] query_i,
  input  logic              excl_head_i,
  output logic              hit_o,
  output logic [PTR_W-1:0]  idx_o
);

  logic [PTR_W-1:0] idx;

  // Walk backwards from the newest slot; the first eligible match wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      idx = tail_i - PTR_W'(k);
      if (!hit_o && valid_i[idx] && (addr_i[idx] == query_i) &&
          !(excl_head_i && (idx == head_i))) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/lc3b_write_buffer.sv
// Write-back buffer between the L1 data cache and the memory port.
// Absorbs dirty evictions, coalesces repeat evictions of a line, forwards buffered
// lines to the miss path and drains oldest-first whenever the arbiter allows.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of lc3b_write_buffer_if:
//            in_write/in_addr/in_data -> in_resp   eviction push, accepted when in_resp=1
//            lk_addr -> lk_hit/lk_data             lookup of buffered lines
//            hold, flush                           drain gating from the arbiter / system
//            empty, full                           occupancy
//            pmem_write/address/wdata, pmem_resp   downstream write handshake
module lc3b_write_buffer
  import lc3b_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 12
) (
  input logic                  clk,
  input logic                  reset_n,
  lc3b_write_buffer_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  lc3b_wb_state      state_q, state_d;

  logic              full;
  logic              empty;
  logic              push_hit;
  logic [PTR_W-1:0]  push_idx;
  logic              lk_hit;
  logic [PTR_W-1:0]  lk_idx;
  logic              coalesce;
  logic              append;
  logic              pop;
  logic              pmem_write;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Coalesce target: the head is off limits while it is being written out.
  lc3b_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_push_match (
    .valid_i     (valid_q),
    .addr_i      (addr_q),
    .head_i      (head_q),
    .tail_i      (tail_q),
    .query_i     (bus.in_addr),
    .excl_head_i (state_q == WB_DRAIN),
    .hit_o       (push_hit),
    .idx_o       (push_idx)
  );

  // Miss-path lookup sees every buffered line, including the in-flight head.
  lc3b_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lk_match (
    .valid_i     (valid_q),
    .addr_i      (addr_q),
    .head_i      (head_q),
    .tail_i      (tail_q),
    .query_i     (bus.lk_addr),
    .excl_head_i (1'b0),
    .hit_o       (lk_hit),
    .idx_o       (lk_idx)
  );

  assign coalesce = bus.in_write && push_hit;
  assign append   = bus.in_write && !push_hit && !full;
  assign pop      = (state_q == WB_DRAIN) && bus.pmem_resp;

  // Storage and pointer next-state; coalesce never targets the popped head.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (coalesce) begin
      data_d[push_idx] = bus.in_data;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (append) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.in_addr;
      data_d[tail_q]  = bus.in_data;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(append) - CNT_W'(pop);
  end

  // Drain FSM next-state; flush overrides hold, hold only gates starting a drain.
  always_comb begin
    state_d    = state_q;
    pmem_write = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (!empty && (!bus.hold || bus.flush)) begin
          state_d = WB_DRAIN;
        end
      end
      WB_DRAIN: begin
        pmem_write = 1'b1;
        if (pop && !((count_q > CNT_W'(1)) && (!bus.hold || bus.flush))) begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= WB_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_resp      = coalesce || append;
  assign bus.lk_hit       = lk_hit;
  assign bus.lk_data      = lk_hit ? data_q[lk_idx] : '0;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.pmem_write   = pmem_write;
  assign bus.pmem_address = addr_q[head_q];
  assign bus.pmem_wdata   = data_q[head_q];

endmodule

// File: tb/tb_lc3b_write_buffer.sv
// Randomised + directed bench for lc3b_write_buffer against a queue-based model.
module tb_lc3b_write_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned ADDR_W = 12;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } ent_t;

  logic clk;
  logic reset_n;

  lc3b_write_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  lc3b_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];     // model contents, oldest first
  ent_t sb[$];     // expected downstream writes, in order
  bit   m_drain;   // model: a write of mq[0] is being presented

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive, check combinational view against the model, advance the model.
  task automatic step(input bit w, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                      input logic [ADDR_W-1:0] lk, input bit h, input bit f, input bit r);
    int sz;
    int mi;
    bit lkh;
    bit pop;
    bit nd;
    logic [LINE_W-1:0] lkd;
    ent_t e;
    @(negedge clk);
    bus.in_write  = w;
    bus.in_addr   = a;
    bus.in_data   = d;
    bus.lk_addr   = lk;
    bus.hold      = h;
    bus.flush     = f;
    bus.pmem_resp = r;
    #1;
    sz  = mq.size();
    lkh = 1'b0;
    lkd = '0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (!lkh && mq[i].addr == lk) begin
        lkh = 1'b1;
        lkd = mq[i].data;
      end
    end
    mi = -1;
    for (int i = sz - 1; i >= (m_drain ? 1 : 0); i--) begin
      if (mi < 0 && mq[i].addr == a) mi = i;
    end
    chk("in_resp", LINE_W'(bus.in_resp), LINE_W'(w && (mi >= 0 || sz < DEPTH)));
    chk("lk_hit", LINE_W'(bus.lk_hit), LINE_W'(lkh));
    chk("lk_data", bus.lk_data, lkd);
    chk("empty", LINE_W'(bus.empty), LINE_W'(sz == 0));
    chk("full", LINE_W'(bus.full), LINE_W'(sz == DEPTH));
    chk("pmem_write", LINE_W'(bus.pmem_write), LINE_W'(m_drain));
    if (m_drain) begin
      chk("pmem_address", LINE_W'(bus.pmem_address), LINE_W'(mq[0].addr));
      chk("pmem_wdata", bus.pmem_wdata, mq[0].data);
    end
    pop = m_drain && r;
    if (pop) sb.push_back(mq[0]);
    if (w && mi >= 0) mq[mi].data = d;
    if (!m_drain)  nd = (sz > 0) && (!h || f);
    else if (pop)  nd = (sz > 1) && (!h || f);
    else           nd = 1'b1;
    if (pop) e = mq.pop_front();
    if (w && mi < 0 && sz < DEPTH) begin
      e.addr = a;
      e.data = d;
      mq.push_back(e);
    end
    m_drain = nd;
  endtask

  task automatic idle(input bit h, input bit f, input bit r);
    step(1'b0, 12'h000, '0, 12'h010, h, f, r);
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input bit h);
    step(1'b1, a, d, a, h, 1'b0, 1'b0);
  endtask

  task automatic drive_quiet();
    bus.in_write  = 1'b0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.lk_addr   = 12'h010;
    bus.hold      = 1'b0;
    bus.flush     = 1'b0;
    bus.pmem_resp = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    m_drain = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_quiet();
    reset_n = 1'b0;
    #1;
    chk("rst_pmem_write", LINE_W'(bus.pmem_write), '0);
    chk("rst_empty", LINE_W'(bus.empty), LINE_W'(1));
    chk("rst_full", LINE_W'(bus.full), '0);
    chk("rst_lk_hit", LINE_W'(bus.lk_hit), '0);
    chk("rst_lk_data", bus.lk_data, '0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: every completed downstream write must match the next expected line.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && bus.pmem_write && bus.pmem_resp) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected", LINE_W'(bus.pmem_address), '1);
        end else begin
          e = sb.pop_front();
          chk("drain_addr", LINE_W'(bus.pmem_address), LINE_W'(e.addr));
          chk("drain_data", bus.pmem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] da, db, dc, dd;
    logic [ADDR_W-1:0] atab [6];
    logic [ADDR_W-1:0] ra;
    int writes;
    atab[0] = 12'h010; atab[1] = 12'h020; atab[2] = 12'h030;
    atab[3] = 12'h040; atab[4] = 12'h050; atab[5] = 12'h060;
    da = rnd_line(); db = rnd_line(); dc = rnd_line(); dd = rnd_line();
    reset_n = 1'b1;
    drive_quiet();
    model_clear();
    do_reset();

    // Single push, then drain two cycles later and complete
    push(12'h010, da, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b0);

    // Fill under hold, stall the fifth push, then back-to-back drain
    push(12'h010, rnd_line(), 1'b1);
    push(12'h020, rnd_line(), 1'b1);
    push(12'h030, rnd_line(), 1'b1);
    push(12'h040, rnd_line(), 1'b1);
    push(12'h050, rnd_line(), 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b0, 1'b0, 1'b1);

    // Coalesce under hold, lookup returns newest data
    push(12'h020, da, 1'b1);
    push(12'h030, db, 1'b1);
    push(12'h020, dc, 1'b1);
    step(1'b0, 12'h000, '0, 12'h020, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b1);

    // Push to the in-flight head appends a second copy
    push(12'h020, da, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    push(12'h020, dd, 1'b0);
    step(1'b0, 12'h000, '0, 12'h020, 1'b0, 1'b0, 1'b0);
    writes = sb.size();
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b1);

    // Flush overrides hold
    push(12'h010, rnd_line(), 1'b1);
    push(12'h020, rnd_line(), 1'b1);
    push(12'h030, rnd_line(), 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b1, 1'b1);

    // Reset during a drain
    push(12'h030, rnd_line(), 1'b0);
    push(12'h040, rnd_line(), 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    bus.pmem_resp = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_pmem_write", LINE_W'(bus.pmem_write), '0);
    chk("mid_rst_empty", LINE_W'(bus.empty), LINE_W'(1));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b0, 1'b0, 1'b0);

    // Full in DRAIN: push together with pmem_resp stalls, next cycle accepted
    push(12'h010, rnd_line(), 1'b1);
    push(12'h020, rnd_line(), 1'b1);
    push(12'h030, rnd_line(), 1'b1);
    push(12'h040, rnd_line(), 1'b1);
    idle(1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h050, da, 12'h050, 1'b0, 1'b0, 1'b1);
    step(1'b1, 12'h050, da, 12'h050, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) idle(1'b0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      ra = atab[$urandom_range(0, 5)];
      step(1'($urandom_range(0, 1)), ra, rnd_line(), atab[$urandom_range(0, 5)],
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end

    // Final flush: everything must come out
    for (int i = 0; i < 4 * DEPTH + 4; i++) idle(1'b1, 1'b1, 1'b1);
    idle(1'b0, 1'b0, 1'b0);
    chk("final_empty", LINE_W'(bus.empty), LINE_W'(1));
    chk("final_sb_left", LINE_W'(sb.size()), '0);
    chk("dup_head_writes_pending", LINE_W'(writes), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
